// File: rtl/test_port_capture_pkg.sv
// Shared definitions for the test-port capture front-end and the result checker.
package test_pkg;

    // Word address of the memory-mapped test port.
    localparam logic [29:0] TEST_ADDR = 30'h40;

    // Framing symbols of the result stream.
    localparam logic [31:0] BEGIN_SYM = 32'h0000_0932;
    localparam logic [31:0] END_SYM   = 32'h0000_0D5D;

    // Width of the sequence index carried with every result word.
    localparam int IDX_W = 6;

    // State encoding shared with the checker FSM.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        CAPTURE = 2'b01,
        DONE    = 2'b10
    } state_e;

    // One buffered result word: index, end-of-stream flag and payload.
    typedef struct packed {
        logic [IDX_W-1:0] index;
        logic             last;
        logic [31:0]      data;
    } entry_t;

endpackage

// File: rtl/test_port_capture_fifo.sv
// Small synchronous FIFO buffering captured result words toward the checker.
// Pointers carry one extra wrap bit so full and empty are told apart without
// a separate occupancy counter.
module capture_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 39
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Status flags, accepted push/pop and next pointer values.
    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop && !empty;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Pointer registers.
    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array write port.
    // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    assign dout = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/test_port_capture.sv
// Test-port capture front-end: snoops CPU data writes to the test port,
// collapses stalled writes into single events, frames the stream between
// BEGIN and END and hands indexed result words to the checker.
module test_port_capture
    import test_pkg::*;
#(
    parameter int MAX_WORDS  = 51,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] addr,
    input  logic [31:0] data,
    input  logic        wen,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [5:0]  out_index,
    output logic        out_last,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [15:0] duration
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_WORDS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [15:0]      dur_q, dur_d;
    logic             ovf_q, ovf_d;
    logic             armed_q, armed_d;

    logic             hit;
    logic             event_fire;
    logic             is_last;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    entry_t           push_entry;
    entry_t           head;

    // Write detection and one-shot arming: a write held through a stall fires once.
    always_comb begin
        hit        = wen && (addr == TEST_ADDR);
        event_fire = hit && armed_q;
        // Disarm while the port is hit; re-arm on the first cycle it is not.
        armed_d    = !hit;
        is_last    = (data == END_SYM) || (cnt_q == LAST_IDX);
        push_entry = '{index: cnt_q, last: is_last, data: data};
    end

    // Capture FSM next state, word counter, duration and overflow.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dur_d   = dur_q;
        ovf_d   = ovf_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (event_fire && (data == BEGIN_SYM)) begin
                    state_d = CAPTURE;
                    cnt_d   = '0;
                    dur_d   = '0;
                end
            end
            CAPTURE: begin
                if (dur_q != 16'hFFFF) begin
                    dur_d = dur_q + 16'd1;
                end
                if (event_fire) begin
                    push  = 1'b1;
                    // The counter advances even for a dropped word so later indices stay aligned.
                    cnt_d = cnt_q + IDX_ONE;
                    if (fifo_full && !pop) begin
                        ovf_d = 1'b1;
                    end
                    if (is_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // Terminal until reset; the FIFO keeps draining.
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and arming registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dur_q   <= '0;
            ovf_q   <= 1'b0;
            armed_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dur_q   <= dur_d;
            ovf_q   <= ovf_d;
            armed_q <= armed_d;
        end
    end

    capture_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (push_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .dout  (head)
    );

    // Output handshake; head fields are forced to zero while the FIFO is empty.
    always_comb begin
        out_valid = !fifo_empty;
        pop       = out_valid && out_ready;
        out_data  = out_valid ? head.data  : '0;
        out_index = out_valid ? head.index : '0;
        out_last  = out_valid ? head.last  : 1'b0;
        busy      = (state_q == CAPTURE);
        done      = (state_q == DONE);
        overflow  = ovf_q;
        duration  = dur_q;
    end

endmodule

// File: tb/tb_test_port_capture.sv
// Self-checking bench for test_port_capture: table-driven vectors feed a
// scoreboard of expected result words that is compared as words are popped.
module tb_test_port_capture;
    import test_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] addr;
    logic [31:0] data;
    logic        wen;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [5:0]  out_index;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [15:0] duration;

    test_port_capture #(
        .MAX_WORDS  (51),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .data      (data),
        .wen       (wen),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .duration  (duration)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_rst;
        logic        wen;
        logic [29:0] addr;
        logic [31:0] data;
        logic        ready;
        logic        exp_push;
        logic [5:0]  exp_idx;
        logic        exp_last;
        logic        exp_busy;
        logic        exp_done;
    } vec_t;

    int     n_vec = 0;
    int     n_err = 0;
    entry_t sb_q[$];
    vec_t   vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t vw(logic [29:0] a, logic [31:0] d, logic rdy, logic p,
                                logic [5:0] idx, logic l, logic b, logic dn);
        vec_t v;
        v.is_rst = 1'b0; v.wen = 1'b1; v.addr = a; v.data = d; v.ready = rdy;
        v.exp_push = p; v.exp_idx = idx; v.exp_last = l; v.exp_busy = b; v.exp_done = dn;
        return v;
    endfunction

    function automatic vec_t vi(logic rdy, logic b, logic dn);
        return vw(30'h0, 32'h0, rdy, 1'b0, 6'd0, 1'b0, b, dn);
    endfunction

    function automatic vec_t vr();
        vec_t v;
        v = vi(1'b1, 1'b0, 1'b0);
        v.is_rst = 1'b1;
        return v;
    endfunction

    // Pulse reset for one edge; optionally confirm every expected word was delivered first.
    task automatic do_reset(input logic check_drained);
        if (check_drained) check("drained", 64'(sb_q.size()), 64'd0);
        wen = 1'b0;
        rst = 1'b1;
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        entry_t e;
        if (v.is_rst) begin
            do_reset(1'b1);
            return;
        end
        wen = v.wen; addr = v.addr; data = v.data; out_ready = v.ready;
        if (v.wen && v.addr != TEST_ADDR) wen = 1'b1;
        if (v.exp_push) begin
            e.index = v.exp_idx; e.last = v.exp_last; e.data = v.data;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        check("busy", 64'(busy), 64'(v.exp_busy));
        check("done", 64'(done), 64'(v.exp_done));
    endtask

    // Scoreboard monitor: every accepted head word must match the oldest expectation.
    always @(negedge clk) begin
        entry_t exp_e;
        entry_t act_e;
        if (!rst && out_valid && out_ready) begin
            check("sb_pending", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                exp_e = sb_q.pop_front();
                act_e = '{index: out_index, last: out_last, data: out_data};
                check("pop", 64'(act_e), 64'(exp_e));
            end
        end
    end

    initial begin
        rst = 1'b1; wen = 1'b0; addr = '0; data = '0; out_ready = 1'b1;
        #3;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_index", 64'(out_index), 64'd0);
        check("rst_flags", 64'({busy, done, overflow, out_last}), 64'd0);
        check("rst_duration", 64'(duration), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic capture; BEGIN inside capture is ordinary data.
        vecs.push_back(vr());
        vecs.push_back(vw(30'h40, BEGIN_SYM, 1, 0, 0, 0, 1, 0));
        vecs.push_back(vi(1, 1, 0));
        vecs.push_back(vw(30'h40, 32'h1, 1, 1, 0, 0, 1, 0));
        vecs.push_back(vi(1, 1, 0));
        vecs.push_back(vw(30'h40, 32'h2, 1, 1, 1, 0, 1, 0));
        vecs.push_back(vi(1, 1, 0));
        vecs.push_back(vw(30'h40, BEGIN_SYM, 1, 1, 2, 0, 1, 0));
        vecs.push_back(vi(1, 1, 0));
        vecs.push_back(vi(1, 1, 0));
        // Write held through a 7-cycle stall yields one event; re-arms after a gap.
        vecs.push_back(vr());
        vecs.push_back(vw(30'h40, BEGIN_SYM, 1, 0, 0, 0, 1, 0));
        vecs.push_back(vi(1, 1, 0));
        vecs.push_back(vw(30'h40, 32'h5, 1, 1, 0, 0, 1, 0));
        for (int i = 0; i < 6; i++) vecs.push_back(vw(30'h40, 32'h5, 1, 0, 0, 0, 1, 0));
        vecs.push_back(vi(1, 1, 0));
        vecs.push_back(vw(30'h40, 32'h6, 1, 1, 1, 0, 1, 0));
        vecs.push_back(vi(1, 1, 0));
        vecs.push_back(vi(1, 1, 0));
        // Other addresses and non-BEGIN writes in IDLE are ignored.
        vecs.push_back(vr());
        vecs.push_back(vw(30'h44, 32'h7, 1, 0, 0, 0, 0, 0));
        vecs.push_back(vi(1, 0, 0));
        vecs.push_back(vw(30'h40, 32'h7, 1, 0, 0, 0, 0, 0));
        vecs.push_back(vi(1, 0, 0));
        vecs.push_back(vw(30'h44, BEGIN_SYM, 1, 0, 0, 0, 0, 0));
        vecs.push_back(vi(1, 0, 0));
        // END closes the stream; later writes are ignored in DONE.
        vecs.push_back(vr());
        vecs.push_back(vw(30'h40, BEGIN_SYM, 1, 0, 0, 0, 1, 0));
        vecs.push_back(vi(1, 1, 0));
        vecs.push_back(vw(30'h40, 32'h1, 1, 1, 0, 0, 1, 0));
        vecs.push_back(vi(1, 1, 0));
        vecs.push_back(vw(30'h40, 32'h2, 1, 1, 1, 0, 1, 0));
        vecs.push_back(vi(1, 1, 0));
        vecs.push_back(vw(30'h40, END_SYM, 1, 1, 2, 1, 0, 1));
        vecs.push_back(vi(1, 0, 1));
        vecs.push_back(vw(30'h40, 32'h9, 1, 0, 0, 0, 0, 1));
        vecs.push_back(vi(1, 0, 1));
        vecs.push_back(vi(1, 0, 1));

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // Full FIFO with push and pop in the same cycle: both happen, no overflow.
        do_reset(1'b1);
        apply(vw(30'h40, BEGIN_SYM, 0, 0, 0, 0, 1, 0));
        apply(vi(0, 1, 0));
        for (int i = 0; i < 4; i++) begin
            apply(vw(30'h40, 32'h10 + 32'(i), 0, 1, 6'(i), 0, 1, 0));
            apply(vi(0, 1, 0));
        end
        apply(vw(30'h40, 32'h20, 1, 1, 4, 0, 1, 0));
        check("ovf_pushpop", 64'(overflow), 64'd0);
        for (int i = 0; i < 6; i++) apply(vi(1, 1, 0));

        // Overflow: six words into four entries, counter keeps counting.
        do_reset(1'b1);
        apply(vw(30'h40, BEGIN_SYM, 0, 0, 0, 0, 1, 0));
        apply(vi(0, 1, 0));
        for (int i = 0; i < 6; i++) begin
            apply(vw(30'h40, 32'h30 + 32'(i), 0, (i < 4), 6'(i), 0, 1, 0));
            apply(vi(0, 1, 0));
        end
        check("ovf_set", 64'(overflow), 64'd1);
        check("ovf_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) apply(vi(1, 1, 0));
        apply(vw(30'h40, 32'h77, 1, 1, 6, 0, 1, 0));
        apply(vi(1, 1, 0));
        apply(vi(1, 1, 0));
        check("ovf_sticky", 64'(overflow), 64'd1);

        // Reset mid-capture clears everything without a clock edge.
        do_reset(1'b1);
        apply(vw(30'h40, BEGIN_SYM, 0, 0, 0, 0, 1, 0));
        apply(vi(0, 1, 0));
        apply(vw(30'h40, 32'h1, 0, 1, 0, 0, 1, 0));
        apply(vi(0, 1, 0));
        apply(vw(30'h40, 32'h2, 0, 1, 1, 0, 1, 0));
        check("dur_count", 64'(duration), 64'd4);
        check("mid_valid", 64'(out_valid), 64'd1);
        wen = 1'b0;
        rst = 1'b1;
        #1;
        check("async_valid", 64'(out_valid), 64'd0);
        check("async_busy", 64'(busy), 64'd0);
        check("async_duration", 64'(duration), 64'd0);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply(vw(30'h40, BEGIN_SYM, 1, 0, 0, 0, 1, 0));
        apply(vi(1, 1, 0));
        apply(vw(30'h40, 32'h3, 1, 1, 0, 0, 1, 0));
        apply(vi(1, 1, 0));
        apply(vi(1, 1, 0));

        // Word limit: the 51st word (index 50) is last and ends the capture.
        do_reset(1'b1);
        apply(vw(30'h40, BEGIN_SYM, 1, 0, 0, 0, 1, 0));
        apply(vi(1, 1, 0));
        for (int i = 0; i < 51; i++) begin
            apply(vw(30'h40, 32'h100 + 32'(i), 1, 1, 6'(i), (i == 50), (i != 50), (i == 50)));
            apply(vi(1, (i != 50), (i == 50)));
        end
        apply(vw(30'h40, 32'h200, 1, 0, 0, 0, 0, 1));
        apply(vi(1, 0, 1));
        apply(vi(1, 0, 1));
        check("drained", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
